rom_access_arbiter: RTL
=======================

// Module: rom_access_arbiter
// PURPOSE
//  Shares the single clocked program ROM read port between two requesters:
//  instruction fetch (req 0) and operand/constant load (req 1).
//  Grants one request per cycle with round-robin priority and drives addr_ROM.
//  Tracks in-flight reads in a tag pipeline and returns each ROM word to its
//  owner. Sits between the control unit's fetch/load logic and the ROM.
// PARAMETERS
//  ADDR_W   8  ROM address width
//  DATA_W   8  ROM data width
//  ROM_LAT  1  cycles from the edge that samples addr_ROM to valid data_out_ROM; legal range >=1
// PORTS
//  clk_ARB         in   1       system clock, all state on rising edge
//  rstn_ARB        in   1       asynchronous, active-low reset
//  fetch_req       in   1       fetch requests a ROM read; hold until fetch_gnt
//  fetch_addr      in   ADDR_W  fetch address; stable while fetch_req=1
//  fetch_gnt       out  1       fetch request accepted this cycle (combinational)
//  fetch_rvalid    out  1       fetch_rdata valid (1-cycle pulse)
//  fetch_rdata     out  DATA_W  returned instruction byte
//  data_req        in   1       operand read request; hold until data_gnt
//  data_addr       in   ADDR_W  operand address
//  data_gnt        out  1       operand request accepted this cycle
//  data_rvalid     out  1       data_rdata valid (1-cycle pulse)
//  data_rdata      out  DATA_W  returned operand byte
//  flush_ARB       in   1       branch taken: discard in-flight fetch reads
//  addr_ROM        out  ADDR_W  address to ROM
//  data_out_ROM    in   DATA_W  ROM read data
// BEHAVIOUR
//  - Reset (async, rstn_ARB=0): all gnt/rvalid = 0; rdata = 0; addr_ROM = 0;
//    tag pipeline cleared; priority pointer = fetch. In-flight reads lost, no rvalid after release.
//  - Arbitration, per cycle: a grant is issued only when a request is pending.
//    - One requester: grant it.
//    - Both requesting: grant the one the priority pointer selects.
//    - After each grant the pointer moves to the other requester.
//    - Never both gnt in one cycle.
//  - flush_ARB=1: fetch_gnt forced 0 that cycle (data may still be granted).
//    Every in-flight tag with id=fetch is invalidated, so no fetch_rvalid for them.
//    Data tags are untouched.
//  - addr_ROM: equals the granted address in the grant cycle.
//    With no grant it holds the last granted address (register).
//  - Latency: a grant in cycle N gives <req>_rvalid=1 in cycle N+ROM_LAT.
//    <req>_rdata = data_out_ROM in that cycle and holds until the next rvalid for that port.
//  - Throughput: one grant per cycle sustained. Reads complete in issue order.
//  - Tag pipeline: ROM_LAT stages of {valid, id}, shifted every cycle.
//    Stage 0 is loaded with {gnt_any, winner}.
//  - A request whose req drops before gnt is simply not served (no error).
// STRUCTURE
//  - cpu_pkg: ROM_ADDR_W, ROM_DATA_W constants; typedef enum logic {REQ_FETCH, REQ_DATA} rom_req_id_t.
//  - Sub-module rom_tag_pipe: ROM_LAT-deep {valid,id} shift register with
//    per-id kill input. The arbiter top holds the priority pointer, grant
//    logic, addr hold register and response demux.
// TESTING  (bench ROM model: data_out_ROM = addr ^ 8'hA5, latency ROM_LAT=1)
//  1. fetch_req alone, addr 0..15 back-to-back -> fetch_gnt every cycle; fetch_rvalid each next cycle with rdata 8'hA5,8'hA4,...,8'hAA.
//  2. Both req every cycle, fetch_addr=8'h10, data_addr=8'h20 -> gnts alternate F,D,F,D; rdata 8'hB5 / 8'h85 on alternating rvalid.
//  3. Fetch granted addr 8'h03, then flush_ARB=1 the next cycle while data_req addr 8'h07 -> no fetch_rvalid; data_rvalid with 8'hA2.
//  4. rstn_ARB low for 1 cycle, 1 cycle after a grant of addr 8'h05 -> no rvalid after release; addr_ROM=0; first grant after release goes to fetch.
//  5. Re-run tests 1-2 with ROM_LAT=3 -> rvalid exactly 3 cycles after each gnt, order preserved, no gaps.

Source files
------------

// File: rtl/rom_access_arbiter_pkg.sv
// Shared constants and types for the program ROM access arbiter.
package cpu_pkg;

    localparam int ROM_ADDR_W = 8;
    localparam int ROM_DATA_W = 8;

    // Owner of a ROM read; the encoding is also the round-robin pointer value.
    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } rom_req_id_t;

    // Requester that gets priority after the given one has been served.
    function automatic rom_req_id_t other_req(input rom_req_id_t id);
        return (id == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    endfunction

endpackage

// File: rtl/rom_access_arbiter_tag_pipe.sv
// In-flight read tracker: a DEPTH-deep {valid, id} shift register that
// follows each ROM read through the ROM latency. The kill input clears
// every stage owned by i_kill_id, including the stage currently presented
// on the outputs, so a killed read never reaches its owner.
module rom_tag_pipe
    import cpu_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  rom_req_id_t i_id,
    input  logic        i_kill,
    input  rom_req_id_t i_kill_id,
    output logic        o_valid,
    output rom_req_id_t o_id
);

    logic [DEPTH-1:0] r_valid;
    rom_req_id_t      r_id [DEPTH];
    logic [DEPTH-1:0] w_valid_eff;

    // Stage validity after applying the per-id kill.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_eff[i] = r_valid[i] & ~(i_kill && (r_id[i] == i_kill_id));
        end
    end

    // Shift every cycle; killed stages propagate as empty slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_id[i] <= REQ_FETCH;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_id[0]    <= i_id;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= w_valid_eff[i-1];
                r_id[i]    <= r_id[i-1];
            end
        end
    end

    assign o_valid = w_valid_eff[DEPTH-1];
    assign o_id    = r_id[DEPTH-1];

endmodule

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing the program ROM read port between
// instruction fetch and operand load, with in-order response routing.
module rom_access_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ROM_ADDR_W,
    parameter int DATA_W  = ROM_DATA_W,
    parameter int ROM_LAT = 1
) (
    input  logic              clk_ARB,
    input  logic              rstn_ARB,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    input  logic              flush_ARB,
    output logic [ADDR_W-1:0] addr_ROM,
    input  logic [DATA_W-1:0] data_out_ROM
);

    rom_req_id_t       r_prio;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_fetch_hold;
    logic [DATA_W-1:0] r_data_hold;

    logic              w_fetch_pend;
    logic              w_data_pend;
    logic              w_gnt_any;
    rom_req_id_t       w_winner;
    logic              w_tag_valid;
    rom_req_id_t       w_tag_id;

    // Requests eligible this cycle; a branch flush blocks new fetches, and
    // nothing is granted while reset is held.
    always_comb begin
        w_fetch_pend = rstn_ARB & fetch_req & ~flush_ARB;
        w_data_pend  = rstn_ARB & data_req;
        w_gnt_any    = w_fetch_pend | w_data_pend;
        if (w_fetch_pend && w_data_pend) begin
            w_winner = r_prio;
        end else if (w_data_pend) begin
            w_winner = REQ_DATA;
        end else begin
            w_winner = REQ_FETCH;
        end
    end

    // Grant decode and ROM address mux; without a grant the last address stays on the bus.
    always_comb begin
        fetch_gnt = w_gnt_any && (w_winner == REQ_FETCH);
        data_gnt  = w_gnt_any && (w_winner == REQ_DATA);
        if (fetch_gnt) begin
            addr_ROM = fetch_addr;
        end else if (data_gnt) begin
            addr_ROM = data_addr;
        end else begin
            addr_ROM = r_addr_hold;
        end
    end

    // Priority pointer and address hold advance only on a grant.
    always_ff @(posedge clk_ARB or negedge rstn_ARB) begin
        if (!rstn_ARB) begin
            r_prio      <= REQ_FETCH;
            r_addr_hold <= '0;
        end else if (w_gnt_any) begin
            r_prio      <= other_req(w_winner);
            r_addr_hold <= addr_ROM;
        end
    end

    rom_tag_pipe #(
        .DEPTH (ROM_LAT)
    ) u_tag_pipe (
        .clk       (clk_ARB),
        .rst_n     (rstn_ARB),
        .i_valid   (w_gnt_any),
        .i_id      (w_winner),
        .i_kill    (flush_ARB),
        .i_kill_id (REQ_FETCH),
        .o_valid   (w_tag_valid),
        .o_id      (w_tag_id)
    );

    // Response demux: ROM data passes straight through on rvalid, then is held.
    always_comb begin
        fetch_rvalid = w_tag_valid && (w_tag_id == REQ_FETCH);
        data_rvalid  = w_tag_valid && (w_tag_id == REQ_DATA);
        fetch_rdata  = fetch_rvalid ? data_out_ROM : r_fetch_hold;
        data_rdata   = data_rvalid  ? data_out_ROM : r_data_hold;
    end

    // Capture returned words so each port's rdata holds until its next rvalid.
    always_ff @(posedge clk_ARB or negedge rstn_ARB) begin
        if (!rstn_ARB) begin
            r_fetch_hold <= '0;
            r_data_hold  <= '0;
        end else begin
            if (fetch_rvalid) begin
                r_fetch_hold <= data_out_ROM;
            end
            if (data_rvalid) begin
                r_data_hold <= data_out_ROM;
            end
        end
    end

endmodule
